// File: rtl/store_align_unit_pkg.sv
// Shared types and helpers for the store alignment path: store sizes,
// controller states and the funct3-to-byte-count mapping.
package store_align_unit_pkg;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010,
        SD = 3'b011
    } store_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        FLAG  = 2'd3
    } store_state_e;

    typedef struct packed {
        logic [7:0] b3;
        logic [7:0] b2;
        logic [7:0] b1;
        logic [7:0] b0;
    } word_st;

    // Zero means "no legal size"; callers also reject sizes wider than the bus.
    function automatic int bytes_of(input logic [2:0] funct3);
        case (funct3)
            SB:      return 1;
            SH:      return 2;
            SW:      return 4;
            SD:      return 8;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/store_align_unit_if.sv
// Request and data-bus signals of the store alignment unit, bundled with
// a unit-side (slave) and environment-side (master) view.
interface store_align_unit_if #(
    parameter int XLEN = 32
);
    localparam int NB = XLEN / 8;

    // Handshake: a request or bus beat transfers on a rising clock edge where
    // valid and ready are both high; once raised, valid and its payload hold
    // steady until that edge.
    logic            req_valid_i;
    logic            req_ready_o;
    logic [XLEN-1:0] addr_i;
    logic [XLEN-1:0] write_data_i;
    logic [2:0]      funct3_i;
    logic            bus_valid_o;
    logic            bus_ready_i;
    logic [XLEN-1:0] bus_addr_o;
    logic [XLEN-1:0] bus_wdata_o;
    logic [NB-1:0]   bus_be_o;
    logic            done_o;
    logic            misaligned_o;
    logic            illegal_o;

    modport slave (
        input  req_valid_i, addr_i, write_data_i, funct3_i, bus_ready_i,
        output req_ready_o, bus_valid_o, bus_addr_o, bus_wdata_o, bus_be_o,
        output done_o, misaligned_o, illegal_o
    );

    modport master (
        output req_valid_i, addr_i, write_data_i, funct3_i, bus_ready_i,
        input  req_ready_o, bus_valid_o, bus_addr_o, bus_wdata_o, bus_be_o,
        input  done_o, misaligned_o, illegal_o
    );

endinterface

// File: rtl/store_align_unit_lane_shift.sv
// Combinational sizing and lane placement of one store across a two-word
// window; the upper word is only populated when the store crosses a boundary.
module store_lane_shift
    import store_align_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]            data,
    input  logic [2:0]                 funct3,
    input  logic [$clog2(XLEN/8)-1:0]  off,
    output logic [2*XLEN-1:0]          wide_data,
    output logic [2*(XLEN/8)-1:0]      wide_be,
    output logic                       crossing,
    output logic                       illegal
);
    localparam int NB = XLEN / 8;

    int              nbytes;
    logic [NB-1:0]   lane_en;
    logic [XLEN-1:0] mask;

    assign nbytes  = bytes_of(funct3);
    assign illegal = (nbytes == 0) || (nbytes > NB);

    // Shifting all-ones left by the size leaves zeros in the active low lanes;
    // a full-width shift yields zero, so the inverse is all-ones as needed.
    assign lane_en = illegal ? '0 : ~({NB{1'b1}} << nbytes);
    assign mask    = illegal ? '0 : ~({XLEN{1'b1}} << (8 * nbytes));

    assign wide_data = {{XLEN{1'b0}}, data & mask} << {off, 3'b000};
    assign wide_be   = {{NB{1'b0}}, lane_en} << off;
    assign crossing  = |wide_be[2*NB-1:NB];

endmodule

// File: rtl/store_align_unit.sv
// Store-path controller: accepts a store, issues one or two lane-placed bus
// beats, or flags the store as misaligned/illegal for a single cycle.
module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter bit SUPPORT_MISALIGNED = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    store_align_unit_if.slave sif,
    output store_state_e   state_o
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    store_state_e      state_q, state_d;
    logic [XLEN-1:0]   addr_q;
    logic [2*XLEN-1:0] wide_data_q, wide_data_d;
    logic [2*NB-1:0]   wide_be_q, wide_be_d;
    logic              crossing_q, crossing_d;
    logic              illegal_q, illegal_d;
    logic [XLEN-1:0]   aligned_addr;
    logic              accept;

    store_lane_shift #(.XLEN(XLEN)) u_lane_shift (
        .data      (sif.write_data_i),
        .funct3    (sif.funct3_i),
        .off       (sif.addr_i[OFFW-1:0]),
        .wide_data (wide_data_d),
        .wide_be   (wide_be_d),
        .crossing  (crossing_d),
        .illegal   (illegal_d)
    );

    assign accept       = (state_q == IDLE) && sif.req_valid_i;
    assign aligned_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign state_o      = state_q;

    // The request is kept in lane-placed form so both beats come straight
    // from registers with no dependence on the live request inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wide_data_q <= '0;
            wide_be_q   <= '0;
            crossing_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q      <= sif.addr_i;
                wide_data_q <= wide_data_d;
                wide_be_q   <= wide_be_d;
                crossing_q  <= crossing_d;
                illegal_q   <= illegal_d;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        sif.req_ready_o  = 1'b0;
        sif.bus_valid_o  = 1'b0;
        sif.bus_addr_o   = '0;
        sif.bus_wdata_o  = '0;
        sif.bus_be_o     = '0;
        sif.done_o       = 1'b0;
        sif.misaligned_o = 1'b0;
        sif.illegal_o    = 1'b0;
        case (state_q)
            IDLE: begin
                sif.req_ready_o = 1'b1;
                if (sif.req_valid_i) begin
                    if (illegal_d || (crossing_d && !SUPPORT_MISALIGNED)) state_d = FLAG;
                    else                                                  state_d = BEAT0;
                end
            end
            BEAT0: begin
                sif.bus_valid_o = 1'b1;
                sif.bus_addr_o  = aligned_addr;
                sif.bus_wdata_o = wide_data_q[XLEN-1:0];
                sif.bus_be_o    = wide_be_q[NB-1:0];
                if (sif.bus_ready_i) begin
                    if (crossing_q) begin
                        state_d = BEAT1;
                    end else begin
                        sif.done_o = !rst_i;
                        state_d    = IDLE;
                    end
                end
            end
            BEAT1: begin
                sif.bus_valid_o = 1'b1;
                sif.bus_addr_o  = aligned_addr + XLEN'(NB);
                sif.bus_wdata_o = wide_data_q[2*XLEN-1:XLEN];
                sif.bus_be_o    = wide_be_q[2*NB-1:NB];
                if (sif.bus_ready_i) begin
                    sif.done_o = !rst_i;
                    state_d    = IDLE;
                end
            end
            FLAG: begin
                sif.illegal_o    = illegal_q;
                sif.misaligned_o = !illegal_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_store_align_unit.sv
// Self-checking bench: two instances (split support on / off) driven with
// directed stores and compared every cycle against a byte-level store model.
module tb_store_align_unit;
    import store_align_unit_pkg::*;

    logic clk;
    logic rst0, rst1;
    store_state_e st0, st1;

    store_align_unit_if #(.XLEN(32)) if0 ();
    store_align_unit_if #(.XLEN(32)) if1 ();

    store_align_unit #(.XLEN(32), .SUPPORT_MISALIGNED(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst0), .sif(if0), .state_o(st0));
    store_align_unit #(.XLEN(32), .SUPPORT_MISALIGNED(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst1), .sif(if1), .state_o(st1));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected beat = {last, be[3:0], data[31:0], addr[31:0]}; flag = {illegal, misaligned}
    logic [68:0] exp_q0[$];
    logic [68:0] exp_q1[$];
    logic [1:0]  ev_q0[$];
    logic [1:0]  ev_q1[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Places each store byte at its absolute address and groups bytes by word.
    function automatic void model_store(input bit sm, input logic [31:0] addr,
                                        input logic [31:0] data, input logic [2:0] f3,
                                        output logic [68:0] b0, output logic [68:0] b1,
                                        output int nbeats, output logic [1:0] ev);
        int nbytes;
        logic [31:0] w0, a;
        logic [31:0] bd[2];
        logic [3:0]  bb[2];
        int idx, lane;
        case (f3)
            3'b000:  nbytes = 1;
            3'b001:  nbytes = 2;
            3'b010:  nbytes = 4;
            default: nbytes = 0;
        endcase
        b0 = '0; b1 = '0; nbeats = 0; ev = 2'b00;
        bd[0] = '0; bd[1] = '0; bb[0] = '0; bb[1] = '0;
        if (nbytes == 0) begin
            ev = 2'b10;
            return;
        end
        w0 = addr & 32'hFFFF_FFFC;
        for (int k = 0; k < nbytes; k++) begin
            a    = addr + 32'(k);
            idx  = ((a & 32'hFFFF_FFFC) == w0) ? 0 : 1;
            lane = int'(a[1:0]);
            bd[idx][8*lane +: 8] = data[8*k +: 8];
            bb[idx][lane] = 1'b1;
        end
        if (bb[1] != 4'b0 && !sm) begin
            ev = 2'b01;
            return;
        end
        nbeats = (bb[1] != 4'b0) ? 2 : 1;
        b0 = {nbeats == 1, bb[0], bd[0], w0};
        b1 = {1'b1, bb[1], bd[1], w0 + 32'd4};
    endfunction

    // ---------------- driver tasks ----------------
    function automatic logic get_ready(input int sel);
        return (sel == 1) ? if1.req_ready_o : if0.req_ready_o;
    endfunction

    function automatic logic get_valid(input int sel);
        return (sel == 1) ? if1.bus_valid_o : if0.bus_valid_o;
    endfunction

    function automatic int pending(input int sel);
        return (sel == 1) ? exp_q1.size() + ev_q1.size() : exp_q0.size() + ev_q0.size();
    endfunction

    task automatic drive_req(input int sel, input logic v, input logic [31:0] a,
                             input logic [31:0] d, input logic [2:0] f);
        if (sel == 1) begin
            if1.req_valid_i = v; if1.addr_i = a; if1.write_data_i = d; if1.funct3_i = f;
        end else begin
            if0.req_valid_i = v; if0.addr_i = a; if0.write_data_i = d; if0.funct3_i = f;
        end
    endtask

    task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f);
        logic [68:0] b0, b1;
        int nb, n;
        logic [1:0] ev;
        model_store(sel == 1, a, d, f, b0, b1, nb, ev);
        n = 0;
        while (!get_ready(sel) && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_wait", get_ready(sel), 1'b1);
        drive_req(sel, 1'b1, a, d, f);
        if (sel == 1) begin
            if (nb > 0) exp_q1.push_back(b0);
            if (nb > 1) exp_q1.push_back(b1);
            if (ev != 2'b00) ev_q1.push_back(ev);
        end else begin
            if (nb > 0) exp_q0.push_back(b0);
            if (nb > 1) exp_q0.push_back(b1);
            if (ev != 2'b00) ev_q0.push_back(ev);
        end
        @(posedge clk); #1;
        drive_req(sel, 1'b0, a, d, f);
        chk("req_ready_busy", get_ready(sel), 1'b0);
        chk("first_beat_latency", get_valid(sel), nb > 0);
    endtask

    task automatic wait_done(input int sel);
        int n = 0;
        while (n < 50 && !(get_ready(sel) && pending(sel) == 0)) begin
            @(posedge clk); #1; n++;
        end
        chk("store_complete", get_ready(sel) && pending(sel) == 0, 1'b1);
    endtask

    // ---------------- scoreboard compare ----------------
    task automatic check_dut(input int sel);
        logic v, r, dn, mi, il, rs;
        logic [31:0] a, d;
        logic [3:0]  be;
        logic [68:0] f;
        logic [1:0]  e;
        int nq, ne;
        if (sel == 1) begin
            v = if1.bus_valid_o; r = if1.bus_ready_i; dn = if1.done_o; mi = if1.misaligned_o;
            il = if1.illegal_o; rs = rst1; a = if1.bus_addr_o; d = if1.bus_wdata_o;
            be = if1.bus_be_o; nq = exp_q1.size(); ne = ev_q1.size();
        end else begin
            v = if0.bus_valid_o; r = if0.bus_ready_i; dn = if0.done_o; mi = if0.misaligned_o;
            il = if0.illegal_o; rs = rst0; a = if0.bus_addr_o; d = if0.bus_wdata_o;
            be = if0.bus_be_o; nq = exp_q0.size(); ne = ev_q0.size();
        end
        if (rs) begin
            if (sel == 1) begin exp_q1.delete(); ev_q1.delete(); end
            else begin exp_q0.delete(); ev_q0.delete(); end
            if (dn !== 1'bx) chk("done_in_reset", dn, 1'b0);
            return;
        end
        if (v) begin
            chk("flag_during_beat", {mi, il}, 2'b00);
            if (nq == 0) begin
                checks++; errors++;
                $display("FAIL beat_unexpected actual addr=%h wdata=%h be=%b expected no beat", a, d, be);
            end else begin
                f = (sel == 1) ? exp_q1[0] : exp_q0[0];
                chk("bus_addr", a, f[31:0]);
                chk("bus_wdata", d, f[63:32]);
                chk("bus_be", be, f[67:64]);
                if (r) begin
                    chk("done_on_handshake", dn, f[68]);
                    if (sel == 1) void'(exp_q1.pop_front()); else void'(exp_q0.pop_front());
                end else begin
                    chk("done_while_stalled", dn, 1'b0);
                end
            end
        end else begin
            chk("done_without_beat", dn, 1'b0);
            if (mi || il) begin
                if (ne == 0) begin
                    checks++; errors++;
                    $display("FAIL flag_unexpected actual={ill,mis}=%b expected none", {il, mi});
                end else begin
                    e = (sel == 1) ? ev_q1[0] : ev_q0[0];
                    chk("flag_kind", {il, mi}, e);
                    if (sel == 1) void'(ev_q1.pop_front()); else void'(ev_q0.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        check_dut(0);
        check_dut(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [68:0] b0, b1;
        int nb;
        logic [1:0] ev;

        rst0 = 1'b1; rst1 = 1'b1;
        drive_req(0, 1'b0, '0, '0, 3'b000);
        drive_req(1, 1'b0, '0, '0, 3'b000);
        if0.bus_ready_i = 1'b1; if1.bus_ready_i = 1'b1;

        // Model pins against hand-computed values
        model_store(1'b1, 32'h0000_1003, 32'hAABB_CCDD, 3'b000, b0, b1, nb, ev);
        chk("pin_sb_addr", b0[31:0], 32'h0000_1000);
        chk("pin_sb_data", b0[63:32], 32'hDD00_0000);
        chk("pin_sb_be", b0[67:64], 4'b1000);
        chk("pin_sb_beats", nb, 1);
        model_store(1'b1, 32'h0000_2001, 32'h1234_BEEF, 3'b001, b0, b1, nb, ev);
        chk("pin_sh_data", b0[63:32], 32'h00BE_EF00);
        chk("pin_sh_be", b0[67:64], 4'b0110);
        model_store(1'b1, 32'h0000_1002, 32'h1122_3344, 3'b010, b0, b1, nb, ev);
        chk("pin_sw_b0_data", b0[63:32], 32'h3344_0000);
        chk("pin_sw_b0_be", b0[67:64], 4'b1100);
        chk("pin_sw_b0_last", b0[68], 1'b0);
        chk("pin_sw_b1_addr", b1[31:0], 32'h0000_1004);
        chk("pin_sw_b1_data", b1[63:32], 32'h0000_1122);
        chk("pin_sw_b1_be", b1[67:64], 4'b0011);
        model_store(1'b0, 32'h0000_1002, 32'h1122_3344, 3'b010, b0, b1, nb, ev);
        chk("pin_mis_flag", {30'd0, ev, nb[1:0]}, {30'd0, 2'b01, 2'b00});
        model_store(1'b0, 32'h0000_1000, 32'h0, 3'b011, b0, b1, nb, ev);
        chk("pin_ill_flag", ev, 2'b10);
        model_store(1'b1, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 3'b010, b0, b1, nb, ev);
        chk("pin_wrap_b1_addr", b1[31:0], 32'h0000_0000);
        chk("pin_wrap_b1_data", b1[63:32], 32'h0000_DEAD);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready0", if0.req_ready_o, 1'b1);
        chk("rst_req_ready1", if1.req_ready_o, 1'b1);
        chk("rst_bus_valid1", if1.bus_valid_o, 1'b0);
        chk("rst_bus_addr1", if1.bus_addr_o, 32'h0);
        chk("rst_bus_wdata1", if1.bus_wdata_o, 32'h0);
        chk("rst_bus_be1", if1.bus_be_o, 4'h0);
        chk("rst_flags1", {if1.done_o, if1.misaligned_o, if1.illegal_o}, 3'b000);
        chk("rst_state0", st0, IDLE);
        chk("rst_state1", st1, IDLE);
        rst0 = 1'b0; rst1 = 1'b0;
        @(posedge clk); #1;

        // Byte store, single beat; ready returns right after the handshake
        issue(1, 32'h0000_1003, 32'hAABB_CCDD, 3'b000);
        @(posedge clk); #1;
        chk("sb_ready_back", if1.req_ready_o, 1'b1);
        wait_done(1);

        issue(1, 32'h0000_2001, 32'h1234_BEEF, 3'b001);
        wait_done(1);

        // Split word store
        issue(1, 32'h0000_1002, 32'h1122_3344, 3'b010);
        wait_done(1);

        // Same store rejected when splitting is unsupported; illegal sizes
        issue(0, 32'h0000_1002, 32'h1122_3344, 3'b010);
        wait_done(0);
        issue(0, 32'h0000_1000, 32'h5555_AAAA, 3'b011);
        wait_done(0);
        issue(1, 32'h0000_1000, 32'h5555_AAAA, 3'b101);
        wait_done(1);
        issue(0, 32'h0000_1004, 32'h0BAD_F00D, 3'b010);
        wait_done(0);

        // Back-pressure on the first beat of a split store
        if1.bus_ready_i = 1'b0;
        issue(1, 32'h0000_1002, 32'h1122_3344, 3'b010);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_req_ready", if1.req_ready_o, 1'b0);
            chk("bp_bus_valid", if1.bus_valid_o, 1'b1);
        end
        if1.bus_ready_i = 1'b1;
        wait_done(1);

        // Reset while the second beat is on the bus
        issue(1, 32'h0000_1002, 32'h1122_3344, 3'b010);
        @(posedge clk); #1;
        chk("in_beat1_valid", if1.bus_valid_o, 1'b1);
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        chk("rst_mid_bus_valid", if1.bus_valid_o, 1'b0);
        chk("rst_mid_req_ready", if1.req_ready_o, 1'b1);
        issue(1, 32'h0000_0004, 32'hCAFE_F00D, 3'b010);
        wait_done(1);

        // Byte and halfword at every offset, plus an address-wrapping split
        for (int i = 0; i < 4; i++) begin
            issue(1, 32'h0000_3000 + 32'(i), 32'h8765_4321 + 32'(i), 3'b000);
            wait_done(1);
            issue(1, 32'h0000_3100 + 32'(i), 32'h0F1E_2D3C, 3'b001);
            wait_done(1);
            issue(0, 32'h0000_3200 + 32'(i), 32'h0F1E_2D3C, 3'b001);
            wait_done(0);
        end
        issue(1, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 3'b010);
        wait_done(1);

        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", pending(0) + pending(1), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
